audio_arbiter: RTL and testbench

AUDIO_ARBITER -- requirements
Module: audio_arbiter

---
 rtl/sfx_pkg.sv | 14 +
 rtl/pwm_gate.sv | 35 +++
 rtl/audio_arbiter.sv | 95 +++++++++
 tb/tb_audio_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared defaults and arbiter state encoding for the sound-effect arbiter.
package sfx_pkg;

    localparam int NUM_SRC_DEF    = 4;
    localparam int GAP_CYCLES_DEF = 50000;
    localparam int PWM_DIV_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pwm_gate.sv
// Volume gate: a prescaled 3-bit ramp compared against the volume level.
module pwm_gate
    import sfx_pkg::*;
#(
    parameter int PWM_DIV = PWM_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] volume,
    output logic       pwm_on
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0] prescaler;
    logic [2:0]       pwm_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (prescaler == PRE_W'(PWM_DIV - 1)) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + 3'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Volume 0 never enables; volume 7 enables 7 of the 8 ramp steps.
    assign pwm_on = (pwm_cnt < volume);

endmodule

// File: rtl/audio_arbiter.sv
// Priority arbiter for sound-effect sources sharing one speaker pin, with a
// silence gap between grants and PWM volume gating of the granted waveform.
module audio_arbiter
    import sfx_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int PWM_DIV    = PWM_DIV_DEF,
    localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] sfx_active,
    input  logic [NUM_SRC-1:0] sfx_wave,
    input  logic [2:0]         volume,
    input  logic               mute,
    output logic               speaker_out,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_SRC - 1);

    arb_state_t       state;
    logic [GAP_W-1:0] gap_cnt;
    logic             any_req;
    logic [IDX_W-1:0] top_req;
    logic             pwm_on;

    pwm_gate #(.PWM_DIV(PWM_DIV)) u_pwm_gate (
        .clk    (clk),
        .reset  (reset),
        .volume (volume),
        .pwm_on (pwm_on)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        any_req = 1'b0;
        top_req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sfx_active[i]) begin
                any_req = 1'b1;
                top_req = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant_idx   <= '0;
            gap_cnt     <= '0;
            speaker_out <= 1'b0;
        end else begin
            speaker_out <= (state == ST_PLAY) & sfx_wave[grant_idx] & pwm_on & ~mute;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_PLAY;
                        grant_idx <= top_req;
                    end
                end
                ST_PLAY: begin
                    // Preemption is checked first so a simultaneous drop of the
                    // current source hands over directly without a gap.
                    if (any_req && (top_req > grant_idx)) begin
                        grant_idx <= top_req;
                    end else if (!sfx_active[grant_idx]) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end
                end
                ST_GAP: begin
                    if (sfx_active[NUM_SRC-1]) begin
                        state     <= ST_PLAY;
                        grant_idx <= TOP_IDX;
                        gap_cnt   <= '0;
                    end else if (gap_cnt == '0) begin
                        state     <= ST_IDLE;
                        grant_idx <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_PLAY);

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench for audio_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_audio_arbiter;

    localparam int N   = 4;
    localparam int GAP = 60;
    localparam int DIV = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sfx_active = '0;
    logic [N-1:0] sfx_wave = '0;
    logic [2:0]   volume = '0;
    logic         mute = 1'b0;
    logic         speaker_out;
    logic [1:0]   grant_idx;
    logic         busy;

    int checks = 0;
    int failures = 0;

    audio_arbiter #(.NUM_SRC(N), .GAP_CYCLES(GAP), .PWM_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .sfx_active  (sfx_active),
        .sfx_wave    (sfx_wave),
        .volume      (volume),
        .mute        (mute),
        .speaker_out (speaker_out),
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: playing / in-gap flags, grant, remaining gap cycles,
    // and the PWM phase derived from the edge count since reset.
    bit m_busy = 1'b0;
    bit m_gap = 1'b0;
    bit m_spk = 1'b0;
    int m_grant = 0;
    int m_gap_left = 0;
    int m_edges = 0;
    int m_hi;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_gap = 1'b0;
            m_spk = 1'b0;
            m_grant = 0;
            m_gap_left = 0;
            m_edges = 0;
        end else begin
            m_hi = -1;
            for (int i = 0; i < N; i++) if (sfx_active[i]) m_hi = i;
            m_spk = m_busy && sfx_wave[m_grant] && (((m_edges / DIV) % 8) < int'(volume)) && !mute;
            if (m_busy) begin
                if (m_hi > m_grant) m_grant = m_hi;
                else if (!sfx_active[m_grant]) begin
                    m_busy = 1'b0;
                    m_gap = 1'b1;
                    m_gap_left = GAP;
                end
            end else if (m_gap) begin
                if (sfx_active[N-1]) begin
                    m_gap = 1'b0;
                    m_busy = 1'b1;
                    m_grant = N - 1;
                end else begin
                    m_gap_left--;
                    if (m_gap_left == 0) begin
                        m_gap = 1'b0;
                        m_grant = 0;
                    end
                end
            end else if (m_hi >= 0) begin
                m_busy = 1'b1;
                m_grant = m_hi;
            end
            m_edges++;
        end
    end

    always @(negedge clk) begin
        check("model_busy", busy, m_busy);
        check("model_grant", grant_idx, m_grant);
        check("model_speaker", speaker_out, m_spk);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic measure_gap(input string name, input int exp_low);
        int low = 0;
        int highs = 0;
        while (!busy && low < 500) begin
            low++;
            if (speaker_out) highs++;
            tick();
        end
        check({name, "_len"}, low, exp_low);
        check({name, "_spk"}, highs, 0);
    endtask

    task automatic window(input string name, input int exp_high, input int exp_busy);
        int highs = 0;
        int busies = 0;
        for (int i = 0; i < 128; i++) begin
            if (speaker_out) highs++;
            if (busy) busies++;
            tick();
        end
        check({name, "_high"}, highs, exp_high);
        check({name, "_busy"}, busies, exp_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        check("rst_speaker", speaker_out, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Lowest source plays, then a full gap before a waiting source is served.
        volume = 3'd7;
        sfx_active[0] = 1'b1;
        sfx_wave[0] = 1'b1;
        tick();
        check("src0_busy", busy, 1);
        check("src0_grant", grant_idx, 0);
        repeat (3) tick();
        window("vol7", 112, 128);
        sfx_active[0] = 1'b0;
        sfx_wave[0] = 1'b0;
        tick();
        sfx_active[1] = 1'b1;
        sfx_wave[1] = 1'b1;
        measure_gap("gap_src0", GAP + 1);
        check("after_gap_grant", grant_idx, 1);

        // Higher source preempts with no gap.
        sfx_active[3] = 1'b1;
        tick();
        check("preempt_busy", busy, 1);
        check("preempt_grant", grant_idx, 3);

        // Lower source waits for the top source and a full gap.
        sfx_active[2] = 1'b1;
        repeat (5) tick();
        check("no_preempt_grant", grant_idx, 3);
        sfx_active[3] = 1'b0;
        sfx_active[1] = 1'b0;
        tick();
        measure_gap("gap_src3", GAP + 1);
        check("src2_grant", grant_idx, 2);

        // Top source aborts a running gap.
        sfx_active[2] = 1'b0;
        tick();
        check("gap_busy", busy, 0);
        repeat (20) tick();
        sfx_active[3] = 1'b1;
        tick();
        check("abort_busy", busy, 1);
        check("abort_grant", grant_idx, 3);

        // Volume and mute gating.
        sfx_wave[3] = 1'b1;
        volume = 3'd3;
        repeat (3) tick();
        window("vol3", 48, 128);
        volume = 3'd0;
        repeat (2) tick();
        window("vol0", 0, 128);
        volume = 3'd7;
        mute = 1'b1;
        repeat (2) tick();
        window("mute", 0, 128);
        mute = 1'b0;

        // Asynchronous reset mid-play, then immediate re-grant.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_speaker", speaker_out, 0);
        check("async_rst_grant", grant_idx, 0);
        check("async_rst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("regrant_busy", busy, 1);
        check("regrant_grant", grant_idx, 3);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 39) == 0) sfx_active[i] = ~sfx_active[i];
            sfx_wave = N'($urandom);
            if ($urandom_range(0, 199) == 0) volume = 3'($urandom);
            if ($urandom_range(0, 299) == 0) mute = ~mute;
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
